logic_gate_pipe: RTL
====================

Name: logic_gate_pipe

Overview:
- Parametrised, pipelined successor to the team's single-bit two-input gates (AND/OR/NAND/NOR/...).
- Performs a selectable bitwise two-operand logic operation on WIDTH-bit vectors.
- Result is registered behind a valid/ready handshake with a one-entry skid buffer, so it can sit directly in a streaming datapath at full throughput.

Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥ 1.
- OPS, 8: number of supported opcodes; fixed at 8, opcode field is 3 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  opcode, sampled with the beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y  out  WIDTH  result
- y_zero  out  1  high when y is all zeros; registered with y

Behaviour:
- Opcodes (bitwise):
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT A (b ignored)
  - 7 PASS A (b ignored)
- Transfers:
  - Input transfer = in_valid & in_ready, sampled at posedge clk.
  - Output transfer = out_valid & out_ready.
- Storage: output register (OR) plus one skid register (SK), each holding {result, zero flag, valid}.
- Latency: a beat accepted in cycle N appears on y/out_valid in cycle N+1 when OR is empty or draining; no combinational path from a/b/op to y.
- in_ready = !SK.valid. It is registered and depends only on state, never combinationally on out_ready.
- State update per posedge, where EMPTY = OR invalid, ONE = OR valid & SK empty, FULL = OR and SK both valid:
  - EMPTY + input: OR <= new; becomes ONE.
  - ONE + input + output: OR <= new; stays ONE.
  - ONE + input, no output: SK <= new; becomes FULL, in_ready drops next cycle.
  - ONE + output, no input: OR invalid; becomes EMPTY.
  - FULL + output: OR <= SK, SK invalid; becomes ONE. No input accepted because in_ready = 0.
  - Otherwise hold.
- Ordering: strict FIFO order; no beat dropped or duplicated.
- Throughput: one beat per cycle sustained while out_ready = 1.
- Stall hold: y, y_zero and out_valid stay stable while out_valid & !out_ready.
- Reset, including mid-operation:
  - out_valid = 0, y = 0, y_zero = 1, in_ready = 1, SK cleared.
  - Any in-flight beats are discarded.
  - Reset is asynchronous on assert, released synchronously by the system.
- in_valid low: a/b/op are don't-care.
- Unused opcode space: none; all 8 codes are defined.

Optional Feature:
- Macro: LOGIC_GATE_PIPE_CNT_EN.
- When defined:
  - Adds output beat_cnt [15:0], counting completed output transfers.
  - Wraps from 16'hFFFF to 0.
  - Reset to 0.
  - Adds input cnt_clr, a synchronous clear; clr takes priority over a same-cycle increment.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package logic_gate_pkg:
  - op_e enum: OP_AND=0 … OP_PASSA=7.
  - Function logic_eval(op, a, b) returning the WIDTH result.
- Natural sub-module: skid_reg (generic one-entry skid buffer, payload width parameter), instantiated once with payload WIDTH+1.
- Opcode decode is combinational in the top level via logic_eval.

Test Plan:
- Truth table sweep: WIDTH=8, out_ready=1, a=8'hF0, b=8'hCC, op 0..7 on consecutive cycles.
  - Expected y: C0, FC, 3F, 03, 3C, C3, 0F, F0, each one cycle after its beat.
  - y_zero=0 throughout.
- NOR zero flag: a=8'hFF, b=8'h00, op=3 -> y=8'h00, y_zero=1.
- Backpressure: stream 4 beats with out_ready=0.
  - Beat 1 lands in OR, beat 2 in SK; in_ready goes 0 the cycle after the 2nd accept.
  - Raise out_ready: all 4 results emerge in order, none lost.
  - y stays stable while stalled.
- Throughput: 100 random beats, in_valid=out_ready=1 -> 100 outputs in 101 cycles, matching a reference model.
- Reset mid-operation: assert rst_n=0 while FULL -> immediately out_valid=0, y=0, in_ready=1; no stale beat after release.
- With LOGIC_GATE_PIPE_CNT_EN:
  - 65537 transfers -> beat_cnt=1.
  - cnt_clr coincident with a transfer -> beat_cnt=0.

Source files
------------

// File: rtl/logic_gate_pipe_pkg.sv
// ---------------------------------------------------------------------------
// logic_gate_pkg
//
// Purpose : shared types and the opcode evaluator for logic_gate_pipe.
//           The evaluator works on a fixed maximum word width (LG_MAX_W).
//           Callers zero-extend their operands into it and keep only the
//           low bits of the result they need.
//
// Contents:
//   LG_MAX_W      widest operand the evaluator supports
//   LG_OPS        number of defined opcodes (3-bit opcode field)
//   op_e          opcode enumeration, OP_AND = 0 ... OP_PASSA = 7
//   skid_state_e  occupancy of the output/skid register pair
//   lg_word_t     evaluator word type
//   logic_eval()  bitwise two-operand operation selected by op
// ---------------------------------------------------------------------------
package logic_gate_pkg;

    localparam int LG_MAX_W = 64;
    localparam int LG_OPS   = 8;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    // EMPTY: nothing held, ONE: output register only, FULL: output + skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef logic [LG_MAX_W-1:0] lg_word_t;

    // Upper bits of the result are garbage for the NOT/NAND/NOR/XNOR
    // opcodes when the operands were zero-extended; callers mask them off.
    function automatic lg_word_t logic_eval(op_e op, lg_word_t a, lg_word_t b);
        lg_word_t res;
        res = a;
        case (op)
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_NAND:  res = ~(a & b);
            OP_NOR:   res = ~(a | b);
            OP_XOR:   res = a ^ b;
            OP_XNOR:  res = ~(a ^ b);
            OP_NOTA:  res = ~a;
            OP_PASSA: res = a;
            default:  res = a;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logic_gate_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// skid_reg
//
// Purpose : generic valid/ready register stage with a one-entry skid buffer.
//           The payload is registered in the output register (OR). When the
//           consumer stalls while a new beat arrives, that beat is parked in
//           the skid register (SK). in_ready is derived only from the state
//           register, so there is no combinational out_ready -> in_ready path.
//
// Parameters:
//   DW         payload width
//   RESET_VAL  value both payload registers take on reset
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat (low only when OR and SK are full)
//   in_data    upstream payload
//   out_valid  OR holds a beat
//   out_ready  downstream accepts the beat in OR
//   out_data   payload held in OR
// ---------------------------------------------------------------------------
module skid_reg
    import logic_gate_pkg::*;
#(
    parameter int            DW        = 9,
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_e   r_state;
    skid_state_e   w_stateNext;
    logic [DW-1:0] r_orData;
    logic [DW-1:0] r_skData;
    logic          w_inXfer;
    logic          w_outXfer;
    logic          w_loadOrNew;
    logic          w_loadOrSk;
    logic          w_loadSk;

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_orData;
    assign w_inXfer  = in_valid & in_ready;
    assign w_outXfer = out_valid & out_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next occupancy and which payload register loads from where.
    // In FULL no input can arrive because in_ready is low.
    always_comb begin
        w_stateNext = r_state;
        w_loadOrNew = 1'b0;
        w_loadOrSk  = 1'b0;
        w_loadSk    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_inXfer) begin
                    w_loadOrNew = 1'b1;
                    w_stateNext = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_inXfer && w_outXfer) begin
                    w_loadOrNew = 1'b1;
                end else if (w_inXfer) begin
                    w_loadSk    = 1'b1;
                    w_stateNext = ST_FULL;
                end else if (w_outXfer) begin
                    w_stateNext = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_outXfer) begin
                    w_loadOrSk  = 1'b1;
                    w_stateNext = ST_ONE;
                end
            end
            default: begin
                w_stateNext = ST_EMPTY;
            end
        endcase
    end

    // Payload registers; contents are kept when a beat leaves so the bus
    // does not toggle needlessly, out_valid alone qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_orData <= RESET_VAL;
            r_skData <= RESET_VAL;
        end else begin
            if (w_loadOrNew) begin
                r_orData <= in_data;
            end else if (w_loadOrSk) begin
                r_orData <= r_skData;
            end
            if (w_loadSk) begin
                r_skData <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// ---------------------------------------------------------------------------
// logic_gate_pipe
//
// Purpose : WIDTH-bit bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT A/
//           PASS A) whose result and zero flag are registered behind a
//           valid/ready handshake with a one-entry skid buffer. A beat
//           accepted in one cycle is presented the next cycle when the
//           output register is empty or draining; full throughput is
//           sustained while out_ready stays high.
//
// Parameters:
//   WIDTH  operand/result width, 1..64
//   OPS    number of opcodes, must be 8
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat
//   a, b       operands
//   op         opcode, sampled with the beat
//   out_valid  result valid
//   out_ready  downstream accepts result
//   y          result
//   y_zero     y is all zeros, registered with y
//
// Optional feature, macro LOGIC_GATE_PIPE_CNT_EN:
//   cnt_clr    synchronous clear of beat_cnt, wins over an increment
//   beat_cnt   16-bit wrapping count of completed output transfers
// ---------------------------------------------------------------------------
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPS   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero
`ifdef LOGIC_GATE_PIPE_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      beat_cnt
`endif
);

    // Parameter sanity is caught at elaboration time
    generate
        if (OPS != LG_OPS || WIDTH < 1 || WIDTH > LG_MAX_W) begin : g_badParam
            $error("logic_gate_pipe: unsupported WIDTH or OPS");
        end
    endgenerate

    // Keeps only the WIDTH live bits of the evaluator word
    localparam lg_word_t W_MASK = {LG_MAX_W{1'b1}} >> (LG_MAX_W - WIDTH);
    localparam logic [WIDTH:0] PAYLOAD_RESET = {1'b1, {WIDTH{1'b0}}};

    lg_word_t         w_aExt;
    lg_word_t         w_bExt;
    lg_word_t         w_evalMasked;
    logic [WIDTH-1:0] w_result;
    logic             w_resultZero;
    logic [WIDTH:0]   w_inData;
    logic [WIDTH:0]   w_outData;

    // Opcode decode and evaluation; the zero flag is computed here so it
    // is registered in lockstep with the result
    always_comb begin
        w_aExt              = '0;
        w_bExt              = '0;
        w_aExt[WIDTH-1:0]   = a;
        w_bExt[WIDTH-1:0]   = b;
        w_evalMasked        = logic_eval(op_e'(op), w_aExt, w_bExt) & W_MASK;
        w_result            = w_evalMasked[WIDTH-1:0];
        w_resultZero        = (w_evalMasked == '0);
    end

    assign w_inData = {w_resultZero, w_result};

    skid_reg #(
        .DW        (WIDTH + 1),
        .RESET_VAL (PAYLOAD_RESET)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_inData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_outData)
    );

    assign y      = w_outData[WIDTH-1:0];
    assign y_zero = w_outData[WIDTH];

`ifdef LOGIC_GATE_PIPE_CNT_EN
    logic [15:0] r_beatCnt;

    // Completed output transfers, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beatCnt <= 16'd0;
        end else if (cnt_clr) begin
            r_beatCnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            r_beatCnt <= r_beatCnt + 16'd1;
        end
    end

    assign beat_cnt = r_beatCnt;
`endif

endmodule
